uart_msg_tx: RTL and testbench

//  Downstream consumer of the enable generator's strobe/index pair. On each

---
 rtl/uart_msg_tx.sv | 100 ++++++++++
 tb/tb_uart_msg_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_tx.sv
// 8N1 UART transmitter that sends one character of a fixed 16-char message per
// accepted strobe, with bit timing from a fractional-N phase accumulator.
module uart_msg_tx #(
    parameter int unsigned       ACC_W    = 32,
    parameter logic [ACC_W-1:0]  BAUD_INC = ACC_W'(10307922),
    parameter logic [127:0]      MESSAGE  = "HELLO UART 2HZ\r\n"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_in,
    input  logic [3:0] index_in,
    output logic       tx,
    output logic       busy,
    output logic [7:0] char_out,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       char_q, char_d;
    logic             tx_q, tx_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             tick;
    logic [ACC_W:0]   sum;

    // Carry out of the accumulator is the baud tick; it acts on the same edge.
    assign sum  = {1'b0, acc_q} + {1'b0, BAUD_INC};
    assign tick = sum[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        char_d  = char_q;
        ovr_d   = ovr_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE:  if (en_in) accept = 1'b1;
            START: if (tick) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA:  if (tick) begin
                if (bit_q == 3'd7) state_d = STOP;
                else               bit_d   = bit_q + 3'd1;
            end
            STOP:  if (tick) begin
                // A strobe on the final stop tick chains the next frame with no gap.
                if (en_in) accept  = 1'b1;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (en_in && !accept && state_q != IDLE) ovr_d = 1'b1;
        if (accept) begin
            state_d = START;
            char_d  = MESSAGE[8*(15-index_in) +: 8];
        end
        acc_d = accept ? '0 : sum[ACC_W-1:0];
    end

    // tx is decoded from next state so the registered line lines up with the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = char_d[bit_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign char_out = char_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Scoreboard bench for uart_msg_tx: stimulus pushes expected frames, a line
// monitor decodes tx at computed mid-bit points and compares.
module tb_uart_msg_tx;

    localparam longint INC = 10307922;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_in;
    logic [3:0] index_in;
    logic       tx, busy, overrun;
    logic [7:0] char_out;

    uart_msg_tx dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .index_in(index_in),
        .tx(tx), .busy(busy), .char_out(char_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        bit         b2b;
    } exp_t;

    exp_t  sb_q[$];
    string MSG = "HELLO UART 2HZ\r\n";
    int    n_chk  = 0;
    int    n_pass = 0;
    bit    ov_model = 0;

    // Edge (counted from the acceptance edge) on which the n-th baud tick lands.
    function automatic int tick_edge(input int n);
        return int'(((longint'(n) << 32) + INC - 1) / INC);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: decode every frame seen on tx and compare with the scoreboard.
    exp_t       e;
    logic [9:0] got;
    bit         pending, aborted;
    int         mid[10];
    int         t10;

    initial begin
        for (int i = 0; i < 10; i++) mid[i] = (tick_edge(i) + tick_edge(i+1)) / 2;
        t10 = tick_edge(10);
        pending = 0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 0;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    e.ch = 8'h00; e.b2b = 0;
                end else begin
                    e = sb_q.pop_front();
                end
                aborted = 0;
                got = '0;
                for (int m = 1; m <= t10; m++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin aborted = 1; break; end
                    for (int i = 0; i < 10; i++) if (m == mid[i]) got[i] = tx;
                    if (m == mid[5])  check("char_out_mid", 32'(char_out), 32'(e.ch));
                    if (m == t10 - 1) check("busy_before_end", 32'(busy), 32'd1);
                    if (m == t10) begin
                        check("busy_at_end", 32'(busy), 32'(e.b2b));
                        if (tx === 1'b0) pending = 1;
                    end
                end
                if (!aborted) check("frame_bits", 32'(got), 32'({1'b1, e.ch, 1'b0}));
            end
        end
    end

    task automatic send(input logic [3:0] idx, input bit b2b);
        exp_t x;
        x.ch = MSG[idx]; x.b2b = b2b;
        sb_q.push_back(x);
        en_in = 1'b1; index_in = idx;
        @(negedge clk);
        en_in = 1'b0;
    endtask

    // Waits until the frame just launched has ended; optionally fires a stray strobe.
    task automatic wait_frame(input int inj);
        for (int m = 1; m <= tick_edge(10); m++) begin
            @(negedge clk);
            if (m == inj) begin
                en_in = 1'b1; index_in = 4'($urandom_range(0, 15)); ov_model = 1;
            end else begin
                en_in = 1'b0;
            end
        end
        en_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en_in = 1'b0; index_in = 4'd0;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_char", 32'(char_out), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);

        // 'H' then '\n'
        send(4'd0, 0);
        check("start_latency", 32'(tx), 32'd0);
        check("char_H", 32'(char_out), 32'h48);
        wait_frame(0);
        repeat (20) @(negedge clk);
        send(4'd15, 0);
        check("char_LF", 32'(char_out), 32'h0A);
        wait_frame(0);
        repeat (20) @(negedge clk);

        // Back-to-back: strobe sampled exactly on the final stop tick.
        send(4'd3, 1);
        for (int m = 1; m < tick_edge(10); m++) @(negedge clk);
        begin
            exp_t x;
            x.ch = MSG[1]; x.b2b = 0;
            sb_q.push_back(x);
        end
        en_in = 1'b1; index_in = 4'd1;
        @(negedge clk);
        en_in = 1'b0;
        check("b2b_char_E", 32'(char_out), 32'h45);
        check("b2b_no_gap", 32'(tx), 32'd0);
        check("b2b_no_ovr", 32'(overrun), 32'd0);
        wait_frame(0);
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 3, then a clean frame.
        send(4'($urandom_range(0, 15)), 0);
        for (int m = 1; m < (tick_edge(4) + tick_edge(5)) / 2; m++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_char", 32'(char_out), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        ov_model = 0;
        repeat (3) @(negedge clk);
        check("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);
        send(4'd7, 0);
        wait_frame(0);
        repeat (10) @(negedge clk);
        check("ovr_clear", 32'(overrun), 32'd0);

        // Random frames, some with a stray strobe mid-frame.
        for (int k = 0; k < 6; k++) begin
            int inj;
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 4100)) : 0;
            repeat ($urandom_range(1, 40)) @(negedge clk);
            send(4'($urandom_range(0, 15)), 0);
            wait_frame(inj);
            @(negedge clk);
            check("rand_ovr", 32'(overrun), 32'(ov_model));
        end

        // Strobe 1000 clks into a frame is dropped and flagged.
        repeat (10) @(negedge clk);
        send(4'd2, 0);
        wait_frame(1000);
        repeat (10) @(negedge clk);
        check("ovr_sticky", 32'(overrun), 32'd1);

        repeat (tick_edge(10) + 20) @(negedge clk);
        check("end_sb_empty", 32'(sb_q.size()), 32'd0);
        check("end_idle_tx", 32'(tx), 32'd1);
        check("end_idle_busy", 32'(busy), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
